// File: rtl/hazard_pkg.sv
// Shared latency encodings and default widths for the hazard scoreboard.
package hazard_pkg;
    localparam int LAT_NONE = 0;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 3;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_MAX_LAT    = 4;
endpackage

// File: rtl/scoreboard_entry.sv
// One per-register result-ready countdown.
module scoreboard_entry
    import hazard_pkg::*;
#(
    parameter int LAT_W   = 3,
    parameter int MAX_LAT = DEF_MAX_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] cnt
);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] dec;
    logic [LAT_W-1:0] lat_c;
    logic [LAT_W-1:0] nxt;

    always_comb begin
        dec   = (cnt != '0) ? cnt - LAT_W'(1) : '0;
        lat_c = (lat > MAX_L) ? MAX_L : lat;
        // An older, slower producer of the same register must still be waited for.
        if (set) nxt = (dec > lat_c) ? dec : lat_c;
        else     nxt = dec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= nxt;
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Register-ready scoreboard producing stall, bubble and multi-cycle flush for the ID stage.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_COUNT   = 32,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MAX_LAT     = DEF_MAX_LAT,
    parameter int LAT_W       = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic                  early_use,
    input  logic                  redirect,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  bubble,
    output logic                  flush,
    output logic [REG_COUNT-1:0]  busy_mask,
    output logic [CNT_W-1:0]      stall_count
);
    localparam int FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_DEPTH - 1);

    logic [LAT_W-1:0] cnt [REG_COUNT];
    logic [FC_W-1:0]  flush_cnt;
    logic [LAT_W-1:0] thr;
    logic             haz1, haz2, stall, do_set;

    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_entry
        logic set_i;
        assign set_i = do_set && (issue_rd == REG_ADDR_W'(i));
        scoreboard_entry #(.LAT_W(LAT_W), .MAX_LAT(MAX_LAT)) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .set   (set_i),
            .lat   (issue_lat),
            .cnt   (cnt[i])
        );
        assign busy_mask[i] = (cnt[i] != '0);
    end

    // Consumers in EX can take a forwarded value one cycle earlier than ID consumers.
    assign thr    = early_use ? '0 : LAT_W'(1);
    assign haz1   = use_rs1 && (id_rs1 != '0) && (cnt[id_rs1] > thr);
    assign haz2   = use_rs2 && (id_rs2 != '0) && (cnt[id_rs2] > thr);
    assign flush  = redirect || (flush_cnt != '0);
    assign stall  = issue_valid && (haz1 || haz2) && !flush;
    assign do_set = issue_valid && issue_we && (issue_rd != '0) && !stall && !flush;

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt   <= '0;
            stall_count <= '0;
        end else begin
            if (redirect)               flush_cnt <= FC_LOAD;
            else if (flush_cnt != '0)   flush_cnt <= flush_cnt - FC_W'(1);
            if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule
